// File: rtl/card18_pulse_gen.sv
// Card 18 timing-line pulse-train generator: emits N low-then-high pulses with
// latched, programmable phase lengths, idling high; one-cycle done strobe at the end.
module card18_pulse_gen #(
   parameter int WIDTH     = 18,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [WIDTH-1:0]     low_len,
   input  logic [WIDTH-1:0]     high_len,
   input  logic [CNT_WIDTH-1:0] num_pulses,
   output logic                 out,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]           state;
   logic [WIDTH-1:0]     low_q;
   logic [WIDTH-1:0]     high_q;
   logic [WIDTH-1:0]     phase_cnt;
   logic [CNT_WIDTH-1:0] pulse_cnt;
   logic [WIDTH-1:0]     low_eff;
   logic [WIDTH-1:0]     high_eff;
   logic                 phase_last;

   // A zero length still yields a one-cycle phase.
   always_comb begin
      low_eff  = (low_len  == '0) ? WIDTH'(1) : low_len;
      high_eff = (high_len == '0) ? WIDTH'(1) : high_len;
   end

   // Reload happens at count 1, so the counter never reaches 0 mid-train.
   assign phase_last = (phase_cnt <= WIDTH'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         low_q     <= '0;
         high_q    <= '0;
         phase_cnt <= '0;
         pulse_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  low_q     <= low_eff;
                  high_q    <= high_eff;
                  phase_cnt <= low_eff;
                  pulse_cnt <= num_pulses;
                  state     <= (num_pulses != '0) ? S_LOW : S_DONE;
               end
            end
            S_LOW: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (phase_last) begin
                  phase_cnt <= high_q;
                  state     <= S_HIGH;
               end else begin
                  phase_cnt <= phase_cnt - WIDTH'(1);
               end
            end
            S_HIGH: begin
               if (abort) begin
                  state <= S_IDLE;
               end else if (phase_last) begin
                  pulse_cnt <= pulse_cnt - CNT_WIDTH'(1);
                  if (pulse_cnt == CNT_WIDTH'(1)) begin
                     state <= S_DONE;
                  end else begin
                     phase_cnt <= low_q;
                     state     <= S_LOW;
                  end
               end else begin
                  phase_cnt <= phase_cnt - WIDTH'(1);
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign out  = (state != S_LOW);
   assign busy = (state == S_LOW) || (state == S_HIGH);
   assign done = (state == S_DONE);

endmodule

// File: doc/card18_pulse_gen.md
# card18_pulse_gen

Programmable pulse-train generator that drives a card 18 timing line (Pin 12 / Pin 34 class signal) from the FPGA side. It is the transmit counterpart of the card 18 delay filter. On a start request it emits a fixed number of low-then-high pulses with programmable phase lengths, idling high in between. Each level is held long enough for the downstream stability filter to accept it. It sits between the sequencing controller (start/abort/done handshake) and the card 18 output pin.

## Interface
Parameters:
- WIDTH, 18, width of the phase-length counters; at 1.28 µs clk, 146875 ≈ 188 ms.
- CNT_WIDTH, 8, width of the pulse-count register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in S_IDLE.
- abort  in  1  terminate current train; sampled in S_LOW/S_HIGH.
- low_len  in  WIDTH  low-phase length in clk cycles; latched on accepted start.
- high_len  in  WIDTH  high-phase length in clk cycles; latched on accepted start.
- num_pulses  in  CNT_WIDTH  pulses per train; latched on accepted start.
- out  out  1  line drive; idle level 1.
- busy  out  1  high while a train is in progress (S_LOW, S_HIGH).
- done  out  1  one-cycle completion strobe.

## Operation
- States: S_IDLE, S_LOW, S_HIGH, S_DONE. All outputs decode the state register only, so they are glitch-free.
- out = 0 iff state == S_LOW. busy = 1 in S_LOW and S_HIGH. done = 1 iff state == S_DONE.
- S_IDLE with start=1:
  - latch low_len, high_len, num_pulses; load the phase counter and the pulse counter.
  - go to S_LOW if num_pulses != 0, else go to S_DONE.
  - start=0 keeps S_IDLE.
- Zero length rule: a latched length of 0 is treated as 1. A phase is never shorter than one cycle.
- S_LOW: the phase counter counts down. On the last cycle of the phase, go to S_HIGH and reload the counter with the effective high length.
- S_HIGH: on the last cycle of the phase, decrement the pulse counter.
  - If this was the final pulse, go to S_DONE.
  - Otherwise go to S_LOW and reload with the effective low length.
- S_DONE: lasts exactly one cycle, then go to S_IDLE. start during S_DONE is ignored, not queued.
- abort=1 in S_LOW or S_HIGH: next state is S_IDLE, so out returns to 1 the next cycle; done is not asserted.
  - abort has priority over phase completion and final-pulse completion.
  - abort in S_IDLE or S_DONE has no effect.
- start while busy is ignored. Inputs changing mid-train have no effect because all parameters are latched.
- Arithmetic:
  - the phase counter is WIDTH bits, unsigned, and never wraps (reload occurs at count 1);
  - the pulse counter is CNT_WIDTH bits; num_pulses = 2^CNT_WIDTH−1 is legal.

## Timing
- Reset (synchronous): state S_IDLE, out=1, busy=0, done=0, all counters and latched registers 0.
  - Reset mid-train aborts immediately; out=1 in the cycle after the reset edge.
- Start latency: start sampled high at edge k gives out=0 and busy=1 from edge k to edge k+1.
- Low phase: out=0 for exactly max(low_len,1) consecutive cycles.
- High phase: out=1 for exactly max(high_len,1) consecutive cycles with busy=1.
- Pulse period: max(low_len,1)+max(high_len,1) cycles. There are no idle cycles between pulses within a train.
- Completion: done=1 for the single cycle immediately after the last high phase; busy=0 in that cycle.
- Earliest next start: sampled in the cycle after done (S_IDLE).
- num_pulses=0: start at edge k gives done=1 in cycle k+1; out stays 1 throughout.
- Total train length from accepted start to done, inclusive: N·(L+H)+1 cycles, where L and H are effective lengths.
- Abort at edge j (state S_LOW/S_HIGH): out=1 and busy=0 from edge j; done stays 0.

## Test plan
- Reset: assert reset 2 cycles during an active train (low_len=8). Required: out=1, busy=0, done=0 the cycle after the first reset edge; the held-low start is not accepted until reset deasserts.
- Single pulse: low_len=8, high_len=8, num_pulses=1, start one cycle.
  - out low exactly 8 cycles starting the cycle after start, then high 8 cycles with busy=1.
  - done=1 exactly on cycle 17 after start; busy=0 in that cycle.
- Multi-pulse with filter: low_len=8, high_len=3, num_pulses=3. Required: out pattern (8 low, 3 high)×3, done on cycle 34.
  - Feed out into timer_card18 (test target 7): the filter follows the low phases only; the 3-cycle highs are rejected.
- Zero/edge lengths: low_len=0, high_len=0, num_pulses=2.
  - Required: out sequence 0,1,0,1, then done.
  - Then num_pulses=0: done one cycle after start, out never low.
- Abort and ignored start: low_len=20, num_pulses=4; assert abort on the 5th low cycle. Required: out=1 and busy=0 next cycle, no done.
  - Also pulse start during S_HIGH and during S_DONE of a normal train; both are ignored (no retrigger, counts unchanged).
- Mid-train input change: change low_len, high_len and num_pulses after start. Required: the train uses the latched values; the next start uses the new values.
